// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage bitwise logic unit with valid/ready handshaking
// on both sides, result flags and a saturating count of delivered results.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       flags,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOTA = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASSB = 3'd7
  } op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  logic [2:0]       s2_flags;

  logic             s1_load;
  logic             s2_load;
  logic             out_xfer;
  logic [WIDTH-1:0] calc_y;
  logic [2:0]       calc_flags;

  // Stage load decisions: a stage may advance when it is empty or its
  // contents leave this cycle; only out_ready feeds into in_ready.
  always_comb begin
    out_xfer = s2_valid & out_ready;
    s2_load  = ~s2_valid | out_ready;
    s1_load  = ~s1_valid | s2_load;
    in_ready = s1_load;
  end

  // Bitwise operation on the S1 operands plus the result flags.
  always_comb begin
    calc_y = '0;
    case (op_e'(s1_op))
      OP_AND:   calc_y = s1_a & s1_b;
      OP_OR:    calc_y = s1_a | s1_b;
      OP_NOTA:  calc_y = ~s1_a;
      OP_NAND:  calc_y = ~(s1_a & s1_b);
      OP_NOR:   calc_y = ~(s1_a | s1_b);
      OP_XOR:   calc_y = s1_a ^ s1_b;
      OP_XNOR:  calc_y = ~(s1_a ^ s1_b);
      OP_PASSB: calc_y = s1_b;
      default:  calc_y = '0;
    endcase
    calc_flags = {~|calc_y, &calc_y, ^calc_y};
  end

  // S1 register: captures operands only on an input transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= a;
        s1_b  <= b;
        s1_op <= op;
      end
    end
  end

  // S2 register: takes the computed result when S1 holds a valid op, so a
  // bubble clears the valid bit but leaves the last result in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_flags <= 3'b100;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y     <= calc_y;
        s2_flags <= calc_flags;
      end
    end
  end

  // Saturating count of delivered results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_xfer && (op_count != CNT_MAX)) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

  assign out_valid = s2_valid;
  assign y         = s2_y;
  assign flags     = s2_flags;

endmodule
